// File: rtl/uart_cmd_seq.sv
// uart_cmd_seq: framed UART read/write command sequencer driving a 32-bit register bus.
//   clk, rstn            : clock, synchronous active-low reset
//   i_rx_vld/dat/stpbt_err : received byte stream from uart_trx
//   o_tx_vld/dat, i_tx_busy: transmit byte handshake to uart_trx
//   o_bus_*/i_bus_*      : single-outstanding register bus transaction
//   o_busy, o_nak_cnt    : status (not in ST_CMD), saturating NAK count
module uart_cmd_seq #(
    parameter int P_IDLE_TIMEOUT = 1_000_000,
    parameter int P_BUS_TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_rx_vld,
    input  logic [7:0]  i_rx_dat,
    input  logic        i_rx_stpbt_err,
    output logic        o_tx_vld,
    output logic [7:0]  o_tx_dat,
    input  logic        i_tx_busy,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdat,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdat,
    output logic        o_busy,
    output logic [7:0]  o_nak_cnt
);
    localparam int IW = $clog2(P_IDLE_TIMEOUT + 1);
    localparam int BW = $clog2(P_BUS_TIMEOUT + 1);
    localparam logic [2:0] ST_CMD  = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_WDAT = 3'd2;
    localparam logic [2:0] ST_BUS  = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;
    localparam logic [2:0] ST_TXH  = 3'd5;
    localparam logic [2:0] ST_TXL  = 3'd6;

    logic [2:0]    state_q, state_d;
    logic          we_q, we_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d, wdat_q, wdat_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [BW-1:0] bto_q, bto_d;
    logic [39:0]   resp_q, resp_d;
    logic [2:0]    left_q, left_d;
    logic          tx_vld_q, tx_vld_d;
    logic [7:0]    tx_dat_q, tx_dat_d;
    logic          bus_req_q, bus_req_d;
    logic          busy_q, busy_d;
    logic [7:0]    nak_cnt_q, nak_cnt_d;
    logic          nak;

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        idle_d    = idle_q;
        bto_d     = bto_q;
        resp_d    = resp_q;
        left_d    = left_q;
        tx_vld_d  = 1'b0;
        tx_dat_d  = tx_dat_q;
        nak_cnt_d = nak_cnt_q;
        nak       = 1'b0;
        case (state_q)
            ST_CMD: begin
                if (i_rx_vld) begin
                    if (!i_rx_stpbt_err && (i_rx_dat == 8'h57 || i_rx_dat == 8'h52)) begin
                        state_d = ST_ADDR;
                        we_d    = i_rx_dat == 8'h57;
                        cnt_d   = 2'd0;
                        idle_d  = '0;
                    end else begin
                        nak = 1'b1;
                    end
                end
            end
            ST_ADDR, ST_WDAT: begin
                // A byte arriving on the timeout cycle still counts and restarts the timer.
                if (i_rx_vld) begin
                    if (i_rx_stpbt_err) begin
                        nak = 1'b1;
                    end else begin
                        idle_d = '0;
                        cnt_d  = cnt_q + 2'd1;
                        if (state_q == ST_ADDR) addr_d = {addr_q[23:0], i_rx_dat};
                        else                    wdat_d = {wdat_q[23:0], i_rx_dat};
                        if (cnt_q == 2'd3) begin
                            state_d = (state_q == ST_ADDR && we_q) ? ST_WDAT : ST_BUS;
                            bto_d   = '0;
                        end
                    end
                end else if (idle_q == IW'(P_IDLE_TIMEOUT - 1)) begin
                    state_d = ST_CMD;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            ST_BUS: begin
                // Ack takes priority over a timeout in the same cycle.
                if (i_bus_ack) begin
                    resp_d  = {8'h06, i_bus_rdat};
                    left_d  = we_q ? 3'd1 : 3'd5;
                    state_d = ST_RESP;
                end else if (bto_q == BW'(P_BUS_TIMEOUT - 1)) begin
                    nak = 1'b1;
                end else begin
                    bto_d = bto_q + 1'b1;
                end
            end
            ST_RESP: begin
                tx_vld_d = 1'b1;
                tx_dat_d = resp_q[39:32];
                resp_d   = {resp_q[31:0], 8'h00};
                left_d   = left_q - 3'd1;
                state_d  = ST_TXH;
            end
            // Wait for busy high then low so the transmitter's vld->busy latency is tolerated.
            ST_TXH: state_d = i_tx_busy ? ST_TXL : ST_TXH;
            ST_TXL: state_d = i_tx_busy ? ST_TXL : (left_q != 3'd0 ? ST_RESP : ST_CMD);
            default: state_d = ST_CMD;
        endcase
        if (nak) begin
            resp_d    = {8'h15, 32'h0};
            left_d    = 3'd1;
            state_d   = ST_RESP;
            nak_cnt_d = nak_cnt_q + {7'd0, nak_cnt_q != 8'hff};
        end
        bus_req_d = state_d == ST_BUS;
        busy_d    = state_d != ST_CMD;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_CMD;
            we_q      <= 1'b0;
            cnt_q     <= 2'd0;
            addr_q    <= 32'h0;
            wdat_q    <= 32'h0;
            idle_q    <= '0;
            bto_q     <= '0;
            resp_q    <= 40'h0;
            left_q    <= 3'd0;
            tx_vld_q  <= 1'b0;
            tx_dat_q  <= 8'h00;
            bus_req_q <= 1'b0;
            busy_q    <= 1'b0;
            nak_cnt_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
            idle_q    <= idle_d;
            bto_q     <= bto_d;
            resp_q    <= resp_d;
            left_q    <= left_d;
            tx_vld_q  <= tx_vld_d;
            tx_dat_q  <= tx_dat_d;
            bus_req_q <= bus_req_d;
            busy_q    <= busy_d;
            nak_cnt_q <= nak_cnt_d;
        end
    end

    assign o_tx_vld   = tx_vld_q;
    assign o_tx_dat   = tx_dat_q;
    assign o_bus_req  = bus_req_q;
    assign o_bus_we   = we_q;
    assign o_bus_addr = addr_q;
    assign o_bus_wdat = wdat_q;
    assign o_busy     = busy_q;
    assign o_nak_cnt  = nak_cnt_q;
endmodule

// File: doc/uart_cmd_seq.md
# uart_cmd_seq

Command sequencer between the `uart_trx` byte interface and a simple 32-bit register bus. It parses framed read/write commands from the RX byte stream and issues one register-bus transaction per command. It then serialises the ACK/NAK response and any read data back through the TX byte interface. It sits directly above `uart_trx` and is the only user of its TX and RX ports.

## Interface
- P_IDLE_TIMEOUT, 1_000_000: max clk cycles between bytes of one frame before the partial frame is dropped
- P_BUS_TIMEOUT, 1024: max clk cycles `o_bus_req` stays high without `i_bus_ack` before NAK
- clk  in  1  system clock (100 MHz)
- rstn  in  1  synchronous, active-low reset
- i_rx_vld  in  1  1-cycle pulse, received byte valid
- i_rx_dat  in  8  received byte, valid with i_rx_vld
- i_rx_stpbt_err  in  1  stop-bit error flag, sampled only with i_rx_vld
- o_tx_vld  out  1  1-cycle pulse, byte to transmit
- o_tx_dat  out  8  transmit byte, valid with o_tx_vld
- i_tx_busy  in  1  transmitter busy
- o_bus_req  out  1  bus request, held until ack or timeout
- o_bus_we  out  1  1 = write, 0 = read; stable while o_bus_req
- o_bus_addr  out  32  address; stable while o_bus_req
- o_bus_wdat  out  32  write data; stable while o_bus_req
- i_bus_ack  in  1  1-cycle completion pulse, sampled only while o_bus_req = 1
- i_bus_rdat  in  32  read data, valid with i_bus_ack
- o_busy  out  1  high in every state except ST_CMD
- o_nak_cnt  out  8  count of NAKs sent, saturates at 0xFF

## Operation
- Frame formats:
  - write: 0x57, then A3 A2 A1 A0, then D3 D2 D1 D0 (MSB first)
  - read: 0x52, then A3 A2 A1 A0
- Responses:
  - write success: 0x06
  - read success: 0x06, then R3 R2 R1 R0
  - any failure: single 0x15 (NAK)
- States and transitions:
  - ST_CMD: accept 0x57/0x52 → ST_ADDR; any other byte → NAK.
  - ST_ADDR: shift in 4 bytes (2-bit counter). After the 4th byte: write → ST_WDAT, read → ST_BUS.
  - ST_WDAT: shift in 4 bytes. After the 4th → ST_BUS.
  - ST_BUS: o_bus_req = 1.
    - i_bus_ack → ST_RESP with ACK (plus R3..R0 for a read).
    - Bus timeout → ST_RESP with NAK.
  - ST_RESP: emit response bytes from a 40-bit shift register, one byte at a time.
    - For each byte: pulse o_tx_vld → ST_TXH.
  - ST_TXH: wait for i_tx_busy = 1 → ST_TXL.
  - ST_TXL: wait for i_tx_busy = 0.
    - More bytes left → ST_RESP.
    - No bytes left → ST_CMD.
- Error handling:
  - i_rx_vld with i_rx_stpbt_err = 1 in ST_CMD/ST_ADDR/ST_WDAT: discard the partial frame, send NAK.
  - Idle timeout in ST_ADDR/ST_WDAT: discard the frame silently (no response) and return to ST_CMD.
- i_rx_vld in ST_BUS/ST_RESP/ST_TXH/ST_TXL is ignored; there is no buffering.
- o_nak_cnt increments by 1 each time a NAK is loaded into the response register, saturating at 0xFF.

## Timing
- Reset values:
  - state = ST_CMD
  - all outputs 0: o_tx_vld, o_tx_dat = 0x00, o_bus_req, o_bus_we, o_bus_addr, o_bus_wdat, o_busy, o_nak_cnt
- All outputs are registered.
- o_bus_req rises on the cycle after the clk edge that accepts the last frame byte.
- o_bus_req falls on the cycle after i_bus_ack is sampled.
- An ack arriving on the first cycle of o_bus_req is legal.
- Bus timeout:
  - A counter is cleared on entry to ST_BUS.
  - NAK is taken when the counter equals P_BUS_TIMEOUT-1 with no ack.
  - An ack arriving in that same cycle wins.
- o_tx_vld pulses for exactly one cycle, on the cycle after entering ST_RESP; o_tx_dat is held until the next pulse.
- The next o_tx_vld is not issued until i_tx_busy has been seen high then low. This tolerates the 3-cycle vld→busy latency of the transmitter.
- Idle timer:
  - cleared on each accepted byte
  - counts only in ST_ADDR/ST_WDAT
  - timeout at P_IDLE_TIMEOUT-1
- A reset mid-frame or mid-response returns to ST_CMD the next cycle. A partially sent response is abandoned.
- Simultaneous idle timeout and i_rx_vld: the byte wins and the timer clears.

## Test plan
- Write frame 57 00 00 10 04 DE AD BE EF, ack after 3 cycles → one o_bus_req with we=1, addr=0x00001004, wdat=0xDEADBEEF; TX emits 06; o_busy low afterwards.
- Read frame 52 00 00 00 08, ack with rdat=0x12345678 → we=0, addr=0x00000008; TX emits 06 12 34 56 78 in order; each o_tx_vld issued only after a busy high→low.
- Unknown command byte 0x41 → TX 15, o_nak_cnt=1, no o_bus_req.
- Read frame with no ack → o_bus_req high for exactly P_BUS_TIMEOUT cycles, then TX 15.
- Write frame stopped after 2 address bytes, idle P_IDLE_TIMEOUT cycles, then valid read frame → no response to the partial frame; read completes normally.
- Stop-bit error on 3rd byte of a read frame, then rstn pulse during the following NAK transmit → NAK started, reset forces ST_CMD with all outputs 0; next frame processed normally.
